// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch sequencing for the beq/bne comparator.
// Detects RAW hazards on the comparator operands against EX/MEM, stalls
// IF/ID while a producer is still in flight, selects the MEM forwarding
// path, turns the comparator result into pc_src/if_flush and keeps
// saturating branch/taken counters.
//
// Stall timing: the first ID cycle of a hazarded branch is itself a stall
// cycle. An ALU result in EX or a load in MEM costs exactly that one bubble;
// the branch is re-evaluated in IDLE next cycle, where the producer has
// moved on (ALU result now in MEM and forwarded, load now in WB and written
// through the regfile). A load in EX needs a second bubble, which is held
// in STALL2 without looking at the hazard inputs, after which IDLE
// re-evaluates and resolves.
module branch_ctrl #(
  parameter int          CNT_W  = 16,
  parameter logic [5:0]  OP_BEQ = 6'b000100,
  parameter logic [5:0]  OP_BNE = 6'b000101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_we,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_load,
  input  logic             mem_we,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_load,
  input  logic             cmpout,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             pc_src,
  output logic             if_flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_STALL2 = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             is_br;
  logic             resolve;
  logic [1:0]       need_a, need_b, need;

  // Bubbles still required before operand r is available in ID
  function automatic logic [1:0] need_of(input logic [4:0] r);
    logic [1:0] n;
    n = 2'd0;
    if (r != 5'd0) begin
      if (ex_we && ex_load && ex_wreg == r)
        n = 2'd2;
      else if ((ex_we && !ex_load && ex_wreg == r) ||
               (mem_we && mem_load && mem_wreg == r))
        n = 2'd1;
    end
    return n;
  endfunction

  // MEM ALU result can be forwarded straight into the comparator
  function automatic logic [1:0] fwd_of(input logic [4:0] r);
    return (r != 5'd0 && mem_we && !mem_load && mem_wreg == r) ? 2'd1 : 2'd0;
  endfunction

  // Hazard evaluation; the worse operand decides
  always_comb begin
    is_br  = id_valid && (id_op == OP_BEQ || id_op == OP_BNE);
    need_a = need_of(id_rs);
    need_b = need_of(id_rt);
    need   = (need_a > need_b) ? need_a : need_b;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: only a load in EX needs the extra held bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (is_br && need == 2'd2) state_d = S_STALL2;
      S_STALL2: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs, forced low while reset is asserted
  always_comb begin
    stall    = 1'b0;
    pc_src   = 1'b0;
    if_flush = 1'b0;
    fwd_a    = 2'd0;
    fwd_b    = 2'd0;
    resolve  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (is_br) begin
            if (need != 2'd0) begin
              stall = 1'b1;
            end else begin
              resolve  = 1'b1;
              fwd_a    = fwd_of(id_rs);
              fwd_b    = fwd_of(id_rt);
              pc_src   = cmpout;
              if_flush = cmpout;
            end
          end
        end
        S_STALL2: stall = 1'b1;
        default:  stall = 1'b0;
      endcase
    end
  end

  // Saturating performance counters, bumped on each resolve
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (resolve && branch_cnt_q != {CNT_W{1'b1}})
      branch_cnt_d = branch_cnt_q + 1'b1;
    if (resolve && cmpout && taken_cnt_q != {CNT_W{1'b1}})
      taken_cnt_d = taken_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule
